speculation_tracker: RTL and testbench

SPECULATION_TRACKER -- requirements
Module: speculation_tracker

---
 rtl/speculation_tracker.sv | 164 ++++++++++++++++
 tb/tb_speculation_tracker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/speculation_tracker.sv
// Speculation tracker: in-order FIFO of predicted branches awaiting resolution.
// Each entry keeps its predictor index, its predicted direction and its age in
// unstalled cycles. Resolving the head produces a registered predictor update.
// A mispredict also reports the head's age as the rollback length and flushes
// every entry.
module speculation_tracker #(
   parameter int unsigned INDEX_W = 6,
   // Deepest rollback that is counted, inclusive.
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pred_valid,
   input  logic [INDEX_W-1:0] pred_index,
   input  logic               pred_taken,
   output logic               pred_ready,
   input  logic               resolve_valid,
   input  logic               resolve_taken,
   input  logic               stall_in,
   output logic               upd_enable,
   output logic [INDEX_W-1:0] upd_index,
   output logic               upd_taken,
   output logic               upd_is_rollback,
   output logic [CNT_W-1:0]   upd_rollback_cycles,
   output logic               is_stalling,
   output logic [CNT_W-1:0]   occupancy,
   output logic               flush_pulse,
   output logic               resolve_err
);

   localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   // Entry storage
   logic [INDEX_W-1:0] idx_q   [DEPTH];
   logic [CNT_W-1:0]   age_q   [DEPTH];
   logic [DEPTH-1:0]   taken_q;
   logic [DEPTH-1:0]   valid_q;
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [CNT_W-1:0]   occ_q;

   // Registered update-side outputs
   logic               upd_enable_q;
   logic [INDEX_W-1:0] upd_index_q;
   logic               upd_taken_q;
   logic               upd_is_rollback_q;
   logic [CNT_W-1:0]   upd_rollback_cycles_q;
   logic               flush_q;
   logic               err_q;

   logic               push, pop, mispredict;
   logic [PTR_W-1:0]   head_nxt, tail_nxt;

   assign is_stalling = stall_in;
   // Readiness looks only at the registered occupancy, so a same-cycle pop
   // never makes room for a push.
   assign pred_ready  = !stall_in && (occ_q < DEPTH_CNT);
   assign push        = pred_valid && pred_ready;
   assign pop         = resolve_valid && !stall_in && (occ_q != '0);
   assign mispredict  = pop && (resolve_taken != taken_q[head_q]);

   // Pointer increments wrapping modulo DEPTH
   always_comb begin
      head_nxt = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
      tail_nxt = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
   end

   // FIFO storage, ageing, push/pop and flush
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx_q[i] <= '0;
            age_q[i] <= '0;
         end
         taken_q <= '0;
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
      end else if (!stall_in) begin
         if (mispredict) begin
            // Flush wins over any push offered in the same cycle
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && (age_q[i] < DEPTH_CNT)) begin
                  age_q[i] <= age_q[i] + CNT_W'(1);
               end
            end
            if (pop) begin
               valid_q[head_q] <= 1'b0;
               head_q          <= head_nxt;
            end
            // The tail slot is always empty when a push is accepted, so the
            // age write below never collides with a live entry's increment.
            if (push) begin
               idx_q[tail_q]   <= pred_index;
               taken_q[tail_q] <= pred_taken;
               age_q[tail_q]   <= CNT_W'(1);
               valid_q[tail_q] <= 1'b1;
               tail_q          <= tail_nxt;
            end
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Predictor update outputs, one cycle after the accepting edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upd_enable_q          <= 1'b0;
         upd_index_q           <= '0;
         upd_taken_q           <= 1'b0;
         upd_is_rollback_q     <= 1'b0;
         upd_rollback_cycles_q <= '0;
         flush_q               <= 1'b0;
      end else if (stall_in) begin
         upd_enable_q          <= 1'b0;
         upd_index_q           <= '0;
         upd_taken_q           <= 1'b0;
         upd_is_rollback_q     <= 1'b0;
         upd_rollback_cycles_q <= '0;
         flush_q               <= 1'b0;
      end else if (pop) begin
         upd_enable_q          <= 1'b1;
         upd_index_q           <= idx_q[head_q];
         upd_taken_q           <= resolve_taken;
         upd_is_rollback_q     <= mispredict;
         upd_rollback_cycles_q <= mispredict ? age_q[head_q] : '0;
         flush_q               <= mispredict;
      end else begin
         upd_enable_q          <= 1'b0;
         upd_index_q           <= '0;
         upd_taken_q           <= push ? pred_taken : 1'b0;
         upd_is_rollback_q     <= 1'b0;
         upd_rollback_cycles_q <= '0;
         flush_q               <= 1'b0;
      end
   end

   // Sticky flag for a resolve seen while nothing is outstanding
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (resolve_valid && !stall_in && (occ_q == '0)) begin
         err_q <= 1'b1;
      end
   end

   assign upd_enable          = upd_enable_q;
   assign upd_index           = upd_index_q;
   assign upd_taken           = upd_taken_q;
   assign upd_is_rollback     = upd_is_rollback_q;
   assign upd_rollback_cycles = upd_rollback_cycles_q;
   assign flush_pulse         = flush_q;
   assign occupancy           = occ_q;
   assign resolve_err         = err_q;

endmodule

// File: tb/tb_speculation_tracker.sv
// Self-checking bench for speculation_tracker: directed vector table, hand
// sequences for fill/stall/reset corners, then random traffic vs a queue model.
module tb_speculation_tracker;

   localparam int INDEX_W = 6;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 3;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               pred_valid = 1'b0;
   logic [INDEX_W-1:0] pred_index = '0;
   logic               pred_taken = 1'b0;
   logic               pred_ready;
   logic               resolve_valid = 1'b0;
   logic               resolve_taken = 1'b0;
   logic               stall_in = 1'b0;
   logic               upd_enable;
   logic [INDEX_W-1:0] upd_index;
   logic               upd_taken;
   logic               upd_is_rollback;
   logic [CNT_W-1:0]   upd_rollback_cycles;
   logic               is_stalling;
   logic [CNT_W-1:0]   occupancy;
   logic               flush_pulse;
   logic               resolve_err;

   speculation_tracker dut (
      .clk                 (clk),
      .reset               (reset),
      .pred_valid          (pred_valid),
      .pred_index          (pred_index),
      .pred_taken          (pred_taken),
      .pred_ready          (pred_ready),
      .resolve_valid       (resolve_valid),
      .resolve_taken       (resolve_taken),
      .stall_in            (stall_in),
      .upd_enable          (upd_enable),
      .upd_index           (upd_index),
      .upd_taken           (upd_taken),
      .upd_is_rollback     (upd_is_rollback),
      .upd_rollback_cycles (upd_rollback_cycles),
      .is_stalling         (is_stalling),
      .occupancy           (occupancy),
      .flush_pulse         (flush_pulse),
      .resolve_err         (resolve_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a queue of outstanding branches
   typedef struct {
      logic [INDEX_W-1:0] idx;
      logic               taken;
      int                 age;
   } ent_t;
   ent_t q[$];

   logic               e_ready, e_en, e_rb, e_taken, e_flush, e_err;
   logic [INDEX_W-1:0] e_idx;
   int                 e_rbc;
   logic               s_ready, s_stall;

   typedef struct {
      logic               pv;
      logic [INDEX_W-1:0] pi;
      logic               pt, rv, rt, st;
      logic               ready, en, rb;
      logic [INDEX_W-1:0] idx;
      logic               taken;
      logic [CNT_W-1:0]   rbc;
      logic               flush;
      logic [CNT_W-1:0]   occ;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle, advances the model across the edge, samples after it
   task automatic drive_cycle(input logic pv, input logic [INDEX_W-1:0] pi, input logic pt,
                              input logic rv, input logic rt, input logic st);
      logic push, pop, mis;
      pred_valid = pv; pred_index = pi; pred_taken = pt;
      resolve_valid = rv; resolve_taken = rt; stall_in = st;
      #1;
      s_ready = pred_ready;
      s_stall = is_stalling;
      e_ready = !st && (q.size() < DEPTH);
      if (st) begin
         e_en = 0; e_rb = 0; e_idx = '0; e_taken = 0; e_rbc = 0; e_flush = 0;
      end else begin
         push = pv && e_ready;
         pop  = rv && (q.size() > 0);
         mis  = 0;
         if (rv && q.size() == 0) e_err = 1;
         if (pop) begin
            mis     = (rt != q[0].taken);
            e_en    = 1;
            e_rb    = mis;
            e_idx   = q[0].idx;
            e_taken = rt;
            e_rbc   = mis ? q[0].age : 0;
            e_flush = mis;
         end else begin
            e_en = 0; e_rb = 0; e_idx = '0; e_taken = push ? pt : 1'b0; e_rbc = 0; e_flush = 0;
         end
         foreach (q[i]) if (q[i].age < DEPTH) q[i].age++;
         if (pop) void'(q.pop_front());
         if (mis) q.delete();
         else if (push) q.push_back('{idx: pi, taken: pt, age: 1});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".ready"},  32'(s_ready),             32'(e_ready));
      chk({tag, ".stall"},  32'(s_stall),             32'(stall_in));
      chk({tag, ".en"},     32'(upd_enable),          32'(e_en));
      chk({tag, ".rb"},     32'(upd_is_rollback),     32'(e_rb));
      chk({tag, ".idx"},    32'(upd_index),           32'(e_idx));
      chk({tag, ".taken"},  32'(upd_taken),           32'(e_taken));
      chk({tag, ".rbc"},    32'(upd_rollback_cycles), 32'(e_rbc));
      chk({tag, ".flush"},  32'(flush_pulse),         32'(e_flush));
      chk({tag, ".occ"},    32'(occupancy),           32'(q.size()));
      chk({tag, ".err"},    32'(resolve_err),         32'(e_err));
   endtask

   // Asserts reset immediately, checks the cleared state, releases at negedge
   task automatic do_reset();
      pred_valid = 0; resolve_valid = 0; stall_in = 0; pred_taken = 0; resolve_taken = 0;
      reset = 1'b0;
      #1;
      chk("rst.occ",   32'(occupancy),           32'd0);
      chk("rst.err",   32'(resolve_err),         32'd0);
      chk("rst.en",    32'(upd_enable),          32'd0);
      chk("rst.rb",    32'(upd_is_rollback),     32'd0);
      chk("rst.taken", 32'(upd_taken),           32'd0);
      chk("rst.idx",   32'(upd_index),           32'd0);
      chk("rst.rbc",   32'(upd_rollback_cycles), 32'd0);
      chk("rst.flush", 32'(flush_pulse),         32'd0);
      q.delete();
      e_err = 0; e_en = 0; e_rb = 0; e_idx = '0; e_taken = 0; e_rbc = 0; e_flush = 0;
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      //            pv pi  pt rv rt st | rdy en rb idx tk rbc fl occ
      tbl[0] = '{1, 6'd3, 1, 0, 0, 0,  1,  0, 0, 6'd0, 1, 3'd0, 0, 3'd1};
      tbl[1] = '{0, 6'd0, 0, 0, 0, 0,  1,  0, 0, 6'd0, 0, 3'd0, 0, 3'd1};
      tbl[2] = '{0, 6'd0, 0, 1, 1, 0,  1,  1, 0, 6'd3, 1, 3'd0, 0, 3'd0};
      tbl[3] = '{1, 6'd5, 0, 0, 0, 0,  1,  0, 0, 6'd0, 0, 3'd0, 0, 3'd1};
      tbl[4] = '{0, 6'd0, 0, 0, 0, 0,  1,  0, 0, 6'd0, 0, 3'd0, 0, 3'd1};
      tbl[5] = '{0, 6'd0, 0, 0, 0, 0,  1,  0, 0, 6'd0, 0, 3'd0, 0, 3'd1};
      tbl[6] = '{0, 6'd0, 0, 1, 1, 0,  1,  1, 1, 6'd5, 1, 3'd3, 1, 3'd0};
      tbl[7] = '{0, 6'd0, 0, 0, 0, 0,  1,  0, 0, 6'd0, 0, 3'd0, 0, 3'd0};

      #2;
      do_reset();

      // Directed vectors: correct resolve, then mispredict after idle ageing
      for (int i = 0; i < 8; i++) begin
         drive_cycle(tbl[i].pv, tbl[i].pi, tbl[i].pt, tbl[i].rv, tbl[i].rt, tbl[i].st);
         chk($sformatf("vec%0d.ready", i), 32'(s_ready),             32'(tbl[i].ready));
         chk($sformatf("vec%0d.en", i),    32'(upd_enable),          32'(tbl[i].en));
         chk($sformatf("vec%0d.rb", i),    32'(upd_is_rollback),     32'(tbl[i].rb));
         chk($sformatf("vec%0d.idx", i),   32'(upd_index),           32'(tbl[i].idx));
         chk($sformatf("vec%0d.taken", i), 32'(upd_taken),           32'(tbl[i].taken));
         chk($sformatf("vec%0d.rbc", i),   32'(upd_rollback_cycles), 32'(tbl[i].rbc));
         chk($sformatf("vec%0d.flush", i), 32'(flush_pulse),         32'(tbl[i].flush));
         chk($sformatf("vec%0d.occ", i),   32'(occupancy),           32'(tbl[i].occ));
      end

      // Fill to capacity; a push offered alongside a resolve is refused
      for (int i = 1; i <= 4; i++) begin
         drive_cycle(1, 6'(i), 1'(i & 1), 0, 0, 0);
         compare_model($sformatf("fill%0d", i));
      end
      chk("full.occ", 32'(occupancy), 32'd4);
      drive_cycle(1, 6'd9, 1, 1, 1, 0);
      chk("full.ready", 32'(s_ready),   32'd0);
      chk("full.occ3",  32'(occupancy), 32'd3);
      chk("full.en",    32'(upd_enable), 32'd1);
      chk("full.idx",   32'(upd_index),  32'd1);
      compare_model("full");
      drive_cycle(0, 6'd0, 0, 0, 0, 0);
      chk("full.ready_next", 32'(s_ready), 32'd1);

      // Stalled cycles do not age the entry
      do_reset();
      drive_cycle(1, 6'd7, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1, 6'd8, 0, 1, 0, 1);
         chk("stall.is_stalling", 32'(s_stall),    32'd1);
         chk("stall.ready",       32'(s_ready),    32'd0);
         chk("stall.en",          32'(upd_enable), 32'd0);
         chk("stall.occ",         32'(occupancy),  32'd1);
      end
      drive_cycle(0, 6'd0, 0, 1, 0, 0);
      chk("stall.rb",    32'(upd_is_rollback),     32'd1);
      chk("stall.rbc",   32'(upd_rollback_cycles), 32'd1);
      chk("stall.idx",   32'(upd_index),           32'd7);
      chk("stall.flush", 32'(flush_pulse),         32'd1);
      chk("stall.occ0",  32'(occupancy),           32'd0);

      // Resolve on empty sets a sticky error; reset mid-stream clears at once
      do_reset();
      drive_cycle(0, 6'd0, 0, 1, 1, 0);
      chk("empty.en",  32'(upd_enable),  32'd0);
      chk("empty.err", 32'(resolve_err), 32'd1);
      drive_cycle(1, 6'd2, 1, 0, 0, 0);
      chk("empty.err_sticky", 32'(resolve_err), 32'd1);
      chk("empty.occ1",       32'(occupancy),   32'd1);
      do_reset();
      drive_cycle(1, 6'd4, 0, 0, 0, 0);
      chk("post_reset.push_occ", 32'(occupancy), 32'd1);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         drive_cycle(1'(($urandom % 2) == 0), 6'($urandom % 64), 1'($urandom % 2),
                     1'(($urandom % 3) == 0), 1'($urandom % 2), 1'(($urandom % 8) == 0));
         compare_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
